// File: rtl/if_fetch.sv
// -----------------------------------------------------------------------------
// if_fetch -- instruction-fetch stage of a 5-stage MIPS pipeline.
//
// Owns the PC and presents if_pc / if_inst to the IF/ID pipeline register.
// One fetch is outstanding at a time on a req/ack instruction bus. While a
// fetch waits for its ack the stage asks the pipeline controller to stall.
// The stage supports:
//   - the shared stall vector (bit 0 holds the PC, bit 2 holds ID),
//   - flush with a redirect address,
//   - ID-stage branch redirects with one delay slot.
//
// Optional feature, selected with the macro IF_ADDR_CHECK_EN:
//   A misaligned PC raises if_excp_adel instead of issuing a fetch.
//   When the macro is undefined, if_excp_adel is tied to 0.
//
// Ports:
//   clk              rising-edge clock
//   rst              synchronous, active-high reset
//   stall[5:0]       pipeline stall vector
//   flush, new_pc    discard fetch state and redirect the PC to new_pc
//   branch_flag_i    ID-stage branch/jump taken
//   branch_target_i  ID-stage branch target
//   inst_req         instruction bus request
//   inst_addr        instruction bus address
//   inst_ack         instruction bus data valid this cycle
//   inst_rdata       instruction bus read data
//   if_pc, if_inst   PC and instruction for IF/ID (if_inst = 0 means nop)
//   stallreq_if      stall request while a fetch is outstanding
//   if_excp_adel     misaligned-fetch exception flag
// -----------------------------------------------------------------------------
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        flush,
  input  logic [31:0] new_pc,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_ack,
  input  logic [31:0] inst_rdata,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        stallreq_if,
  output logic        if_excp_adel
);

`ifdef IF_ADDR_CHECK_EN
  localparam bit ADDR_CHECK = 1'b1;
`else
  localparam bit ADDR_CHECK = 1'b0;
`endif

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_buf_q, inst_buf_d;
  logic        pend_valid_q, pend_valid_d;
  logic [31:0] pend_target_q, pend_target_d;
  logic        adel_q, adel_d;

  logic        branch_take;
  logic        advance;
  logic [31:0] next_pc;
  logic        enter;      // moving to a fresh fetch this cycle
  logic [31:0] enter_pc;   // address that fresh fetch would use
  logic        enter_bad;  // fresh fetch address fails the alignment check

  assign branch_take = branch_flag_i & ~stall[2];
  assign advance     = (state_q == ST_DONE) & ~stall[0];

  // A branch seen in the advance cycle wins over an older pending one.
  // The delay slot is the instruction at pc, which is already fetched.
  assign next_pc = branch_take  ? branch_target_i :
                   pend_valid_q ? pend_target_q   :
                                  pc_q + 32'd4;

  assign enter_bad = ADDR_CHECK && (enter_pc[1:0] != 2'b00);

  always_comb begin
    // NOTE: every next-state signal takes its hold value first. A path that
    // leaves one unassigned would infer a latch.
    state_d       = state_q;
    pc_d          = pc_q;
    inst_buf_d    = inst_buf_q;
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;
    adel_d        = adel_q;
    enter         = 1'b0;
    enter_pc      = pc_q;

    if (flush) begin
      // Flush overrides stall, branch and ack. An ack in this cycle is dropped.
      pc_d         = new_pc;
      pend_valid_d = 1'b0;
      enter        = 1'b1;
      enter_pc     = new_pc;
    end else begin
      case (state_q)
        ST_IDLE: begin
          enter = 1'b1;
        end
        ST_REQ: begin
          if (inst_ack) begin
            inst_buf_d = inst_rdata;
            state_d    = ST_DONE;
          end
        end
        ST_DONE: begin
          if (advance) begin
            pc_d     = next_pc;
            enter    = 1'b1;
            enter_pc = next_pc;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase

      // Any PC advance consumes the pending redirect, or supersedes it.
      // Otherwise a taken branch is remembered until the next advance.
      if (advance) begin
        pend_valid_d = 1'b0;
      end else if (branch_take) begin
        pend_valid_d  = 1'b1;
        pend_target_d = branch_target_i;
      end
    end

    // A misaligned fetch is never issued. The stage parks in DONE with a nop
    // and the exception flag set.
    if (enter) begin
      if (enter_bad) begin
        state_d    = ST_DONE;
        inst_buf_d = 32'h0;
        adel_d     = 1'b1;
      end else begin
        state_d    = ST_REQ;
        adel_d     = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only. All
    // registers see the pre-edge values, whatever the statement order.
    if (rst) begin
      state_q       <= ST_IDLE;
      pc_q          <= RESET_PC;
      inst_buf_q    <= 32'h0;
      pend_valid_q  <= 1'b0;
      pend_target_q <= 32'h0;
      adel_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inst_buf_q    <= inst_buf_d;
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
      adel_q        <= adel_d;
    end
  end

  // Outputs decode registered state. stallreq_if also looks at the live ack,
  // so a zero-wait fetch never stalls the pipeline.
  assign inst_req     = (state_q == ST_REQ);
  assign inst_addr    = pc_q;
  assign if_pc        = pc_q;
  assign if_inst      = (state_q == ST_DONE) ? inst_buf_q : 32'h0;
  assign stallreq_if  = (state_q == ST_REQ) & ~inst_ack;
  assign if_excp_adel = adel_q & (state_q == ST_DONE);

endmodule
